// File: rtl/vote_collector.sv
// -----------------------------------------------------------------------------
// vote_collector
//   Collects one ballot from N_VOTERS voters inside a fixed-length voting
//   window. Each voter locks in a single "for" or "against" vote. The window
//   closes after WINDOW_CYCLES sampling cycles, or earlier once every voter has
//   voted. The final result is then presented with a one-cycle ballot_valid
//   pulse. votes/voted are held until the next ballot is opened.
//
// Ports
//   clk          : system clock, all logic on the rising edge
//   rst_n        : synchronous active-low reset
//   start        : open a new ballot (honoured only in IDLE)
//   yes_btn      : per-voter "for" request, level sampled each clock
//   no_btn       : per-voter "against" request, level sampled each clock
//   votes        : ballot result per voter, 1 = for, 0 = against/abstain
//   voted        : per-voter lock flag, 1 = ballot recorded
//   busy         : high while the voting window is open
//   ballot_valid : one-cycle pulse, votes is final and stable
//   remaining    : cycles left in the window, 0 outside OPEN
// -----------------------------------------------------------------------------
module vote_collector #(
    parameter int N_VOTERS      = 11,
    parameter int WINDOW_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_VOTERS-1:0] yes_btn,
    input  logic [N_VOTERS-1:0] no_btn,
    output logic [N_VOTERS-1:0] votes,
    output logic [N_VOTERS-1:0] voted,
    output logic                busy,
    output logic                ballot_valid,
    output logic [15:0]         remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] WINDOW_LOAD = 16'(WINDOW_CYCLES);

    state_t state;

    // A request only counts for a voter who has not locked yet and who is
    // pressing exactly one of the two buttons; pressing both is ignored so the
    // voter can still vote in a later cycle.
    logic [N_VOTERS-1:0] cast_yes;
    logic [N_VOTERS-1:0] cast_no;

    assign cast_yes = ~voted & yes_btn & ~no_btn;
    assign cast_no  = ~voted & no_btn  & ~yes_btn;

    // NOTE: every register here is updated with non-blocking assignments so
    // all state changes take effect together at the clock edge, independent
    // of statement order inside the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            votes        <= '0;
            voted        <= '0;
            busy         <= 1'b0;
            ballot_valid <= 1'b0;
            remaining    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ballot_valid <= 1'b0;
                    if (start) begin
                        state     <= OPEN;
                        votes     <= '0;
                        voted     <= '0;
                        busy      <= 1'b1;
                        remaining <= WINDOW_LOAD;
                    end
                end

                OPEN: begin
                    // Sampling happens in every OPEN cycle, including the last.
                    votes <= votes | cast_yes;
                    voted <= voted | cast_yes | cast_no;
                    // Close after the cycle showing remaining=1, or after the
                    // cycle in which every voter is already locked. The <= also
                    // keeps the counter from wrapping below zero.
                    if ((remaining <= 16'd1) || (&voted)) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        ballot_valid <= 1'b1;
                        remaining    <= '0;
                    end else begin
                        remaining <= remaining - 16'd1;
                    end
                end

                DONE: begin
                    // Result already final; drop the pulse and rest in IDLE
                    // with votes/voted held.
                    ballot_valid <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    ballot_valid <= 1'b0;
                    remaining    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/vote_collector.md
VOTE_COLLECTOR -- requirements
Module: vote_collector

Interface
REQ-001 Parameter N_VOTERS, default 11, number of voters; fixed at 11 for this product.
REQ-002 Parameter WINDOW_CYCLES, default 1000, length of the voting window in clock cycles; legal range 2..65535.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  open a new ballot; honoured only in IDLE.
REQ-006 yes_btn  input  N_VOTERS  per-voter "for" request, level, sampled every clock.
REQ-007 no_btn  input  N_VOTERS  per-voter "against" request, level, sampled every clock.
REQ-008 votes  output  N_VOTERS  ballot result, 1 = for, 0 = against/abstain; drives the majority-decision stage.
REQ-009 voted  output  N_VOTERS  per-voter lock flag, 1 = ballot recorded.
REQ-010 busy  output  1  high while the window is open.
REQ-011 ballot_valid  output  1  one-cycle pulse; votes is final and stable.
REQ-012 remaining  output  16  cycles left in the window, 0 outside OPEN.

Function
REQ-013 The block SHALL implement the FSM IDLE -> OPEN -> DONE -> IDLE, with all outputs registered.
REQ-014 IDLE: start=1 SHALL enter OPEN next cycle, clear votes and voted, and load remaining=WINDOW_CYCLES.
REQ-015 OPEN: busy=1; remaining SHALL decrement by 1 each cycle and never wrap below 0.
REQ-016 OPEN: for voter i with voted[i]=0, yes_btn[i]=1 and no_btn[i]=0 SHALL set votes[i]=1 and voted[i]=1 next cycle.
REQ-017 OPEN: for voter i with voted[i]=0, no_btn[i]=1 and yes_btn[i]=0 SHALL leave votes[i]=0 and set voted[i]=1.
REQ-018 Simultaneous yes_btn[i] and no_btn[i] SHALL be ignored: no lock, voter may vote in a later cycle.
REQ-019 Once voted[i]=1, further inputs for voter i SHALL be ignored until the next start; a vote cannot be changed.
REQ-020 Inputs SHALL be sampled in every OPEN cycle, including the final cycle (remaining=1).
REQ-021 OPEN -> DONE SHALL occur after the cycle in which remaining=1, giving exactly WINDOW_CYCLES sampling cycles.
REQ-022 OPEN -> DONE SHALL occur early, on the cycle after voted becomes all ones.
REQ-023 DONE SHALL last one cycle with ballot_valid=1, busy=0, remaining=0, then return to IDLE.
REQ-024 Voters not locked at close SHALL count as against (votes[i]=0).
REQ-025 votes and voted SHALL hold their values from DONE through IDLE until the next accepted start.
REQ-026 start in OPEN or DONE SHALL be ignored, with no restart and no timer reload.
REQ-027 Inputs in IDLE or DONE SHALL have no effect.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE with votes=0, voted=0, busy=0, ballot_valid=0 and remaining=0, in any state.
REQ-029 Reset mid-OPEN SHALL abort the ballot with no ballot_valid pulse; start is ignored while rst_n=0.

Verification
REQ-030 WINDOW_CYCLES=8; start; yes on voters 0-5 at cycle 2, no on voters 6-10 at cycle 3 -> early DONE the cycle after all are locked; ballot_valid pulse; votes=11'h03F; voted=11'h7FF.
REQ-031 WINDOW_CYCLES=8; start; yes on voters 0-4 only -> ballot_valid exactly 8 cycles after OPEN entry (plus the DONE cycle); votes=11'h01F; voted=11'h01F.
REQ-032 Voter 3 yes at cycle 1, then no at cycle 2 -> votes[3]=1; voter 7 yes+no together at cycle 1, then no at cycle 2 -> voted[7]=1, votes[7]=0.
REQ-033 Yes on voter 10 while remaining=1 -> recorded, votes[10]=1; start pulsed mid-OPEN -> remaining keeps decrementing, no restart.
REQ-034 rst_n=0 mid-OPEN with 4 voters locked -> next cycle all outputs 0 and IDLE; no ballot_valid; new start gives a clean ballot.
REQ-035 Yes on all voters in IDLE before start -> votes=0, voted=0; after DONE, votes held stable for 20 IDLE cycles.
